fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline, directly upstream of the decode stage. It owns the program counter and looks up the instruction cache at the current PC. It handles cache misses with a small state machine and applies control-flow redirects (trap, IRET, taken branch). It drives the IF/ID pipeline register that the decode stage consumes: instruction, PCNEXT, fetch PC and instruction-TLB-miss flag.

---
 rtl/fetch_stage_if.sv | 14 +
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-cache / ITLB lookup bus between the fetch stage (master) and the cache (slave).
interface fetch_stage_if;
    logic [31:0] ic_addr;
    logic        ic_miss_req;
    logic        itlb_miss;
    logic        ic_hit;
    logic [31:0] ic_rdata;
    logic        ic_fill_done;

    modport master (output ic_addr, ic_miss_req,
                    input  itlb_miss, ic_hit, ic_rdata, ic_fill_done);
    modport slave  (input  ic_addr, ic_miss_req,
                    output itlb_miss, ic_hit, ic_rdata, ic_fill_done);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, looks up the icache, sequences misses,
// applies trap/iret/branch redirects and drives the IF/ID register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_1000,
    parameter logic [31:0] TRAP_PC   = 32'h0000_2000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          EN_REG_FETCH,
    input  logic          flush,
    input  logic          branch_taken,
    input  logic [31:0]   branch_target,
    input  logic          trap,
    input  logic          iret,
    input  logic [31:0]   iret_pc,
    fetch_stage_if.master ic,
    output logic          block_pipe_instr_cache,
    output logic [31:0]   instruction,
    output logic [31:0]   PCNEXT,
    output logic [31:0]   PC_INIT,
    output logic          TLB_MISS_INST
);
    typedef enum logic {RUN, MISS_WAIT} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcnext;
        logic [31:0] pcinit;
        logic        tlb;
    } ifid_t;

    localparam ifid_t IFID_NOP = '{instr: NOP_INSTR, pcnext: '0, pcinit: '0, tlb: 1'b0};

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt, pc_plus4;
    logic [31:0] pend_pc, pend_pc_nxt;
    logic        pend_vld, pend_vld_nxt;
    logic [1:0]  pend_prio, pend_prio_nxt;
    ifid_t       ifid, ifid_nxt;
    logic        redirect, miss_req;
    logic [31:0] redir_tgt;
    logic [1:0]  redir_prio;

    assign pc_plus4 = pc + 32'd4;

    // Priority encode: trap(3) > iret(2) > branch(1).
    always_comb begin
        redirect   = trap | iret | branch_taken;
        redir_tgt  = branch_target;
        redir_prio = branch_taken ? 2'd1 : 2'd0;
        if (trap) begin
            redir_tgt  = TRAP_PC;
            redir_prio = 2'd3;
        end else if (iret) begin
            redir_tgt  = iret_pc;
            redir_prio = 2'd2;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        pend_pc_nxt   = pend_pc;
        pend_vld_nxt  = pend_vld;
        pend_prio_nxt = pend_prio;
        ifid_nxt      = ifid;
        miss_req      = 1'b0;
        case (state)
            RUN: begin
                if (redirect) begin
                    pc_nxt = redir_tgt;
                    if (EN_REG_FETCH) ifid_nxt = IFID_NOP;
                end else if (ic.itlb_miss) begin
                    // PC holds; the downstream trap will redirect us.
                    if (EN_REG_FETCH) ifid_nxt = '{NOP_INSTR, pc_plus4, pc, 1'b1};
                end else if (ic.ic_hit) begin
                    if (EN_REG_FETCH) begin
                        ifid_nxt = '{ic.ic_rdata, pc_plus4, pc, 1'b0};
                        pc_nxt   = pc_plus4;
                    end
                end else begin
                    miss_req  = 1'b1;
                    state_nxt = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                // A held redirect is only displaced by one of equal or higher priority.
                if (redirect && (!pend_vld || redir_prio >= pend_prio)) begin
                    pend_pc_nxt   = redir_tgt;
                    pend_vld_nxt  = 1'b1;
                    pend_prio_nxt = redir_prio;
                end
                if (ic.ic_fill_done) begin
                    state_nxt = RUN;
                    if (pend_vld_nxt) pc_nxt = pend_pc_nxt;
                    pend_vld_nxt  = 1'b0;
                    pend_prio_nxt = 2'd0;
                end
            end
            default: state_nxt = RUN;
        endcase
        if (flush) ifid_nxt = IFID_NOP;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            pc        <= RESET_PC;
            pend_pc   <= '0;
            pend_vld  <= 1'b0;
            pend_prio <= 2'd0;
            ifid      <= IFID_NOP;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            pend_pc   <= pend_pc_nxt;
            pend_vld  <= pend_vld_nxt;
            pend_prio <= pend_prio_nxt;
            ifid      <= ifid_nxt;
        end
    end

    assign ic.ic_addr     = pc;
    assign ic.ic_miss_req = miss_req & reset;
    assign block_pipe_instr_cache = (state == MISS_WAIT) |
        ((state == RUN) & ~ic.ic_hit & ~ic.itlb_miss & ~redirect);

    assign instruction   = ifid.instr;
    assign PCNEXT        = ifid.pcnext;
    assign PC_INIT       = ifid.pcinit;
    assign TLB_MISS_INST = ifid.tlb;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table with a scoreboard of IF/ID results.
module tb_fetch_stage;
    localparam logic [31:0] PAT = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        EN_REG_FETCH, flush, branch_taken, trap, iret;
    logic [31:0] branch_target, iret_pc;
    logic        block_pipe_instr_cache, TLB_MISS_INST;
    logic [31:0] instruction, PCNEXT, PC_INIT;

    fetch_stage_if bus();

    fetch_stage dut (
        .clk(clk), .reset(reset), .EN_REG_FETCH(EN_REG_FETCH), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .trap(trap), .iret(iret), .iret_pc(iret_pc), .ic(bus),
        .block_pipe_instr_cache(block_pipe_instr_cache), .instruction(instruction),
        .PCNEXT(PCNEXT), .PC_INIT(PC_INIT), .TLB_MISS_INST(TLB_MISS_INST)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en, fl, br, tr, ir, itlb, hit, fill;
        logic [31:0] tgt, ipc;
        logic [31:0] e_addr;
        logic        e_req, e_blk;
        logic [31:0] e_ins, e_pcn, e_pci;
        logic        e_tlb;
    } vec_t;

    typedef struct {
        logic [31:0] ins, pcn, pci;
        logic        tlb;
    } ifid_t;

    vec_t  tbl[$];
    ifid_t sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic logic [31:0] wd(input logic [31:0] a);
        return a ^ PAT;
    endfunction

    function automatic vec_t mk(input int en, fl, br, input logic [31:0] tgt,
                                input int tr, ir, input logic [31:0] ipc,
                                input int itlb, hit, fill,
                                input logic [31:0] addr, input int req, blk,
                                input logic [31:0] ins, pcn, pci, input int tlb);
        vec_t v;
        v.en = (en != 0); v.fl = (fl != 0); v.br = (br != 0); v.tgt = tgt;
        v.tr = (tr != 0); v.ir = (ir != 0); v.ipc = ipc;
        v.itlb = (itlb != 0); v.hit = (hit != 0); v.fill = (fill != 0);
        v.e_addr = addr; v.e_req = (req != 0); v.e_blk = (blk != 0);
        v.e_ins = ins; v.e_pcn = pcn; v.e_pci = pci; v.e_tlb = (tlb != 0);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        EN_REG_FETCH = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = '0;
        trap = 1'b0; iret = 1'b0; iret_pc = '0;
        bus.itlb_miss = 1'b1; bus.ic_hit = 1'b0; bus.ic_rdata = 32'hDEAD_BEEF;
        bus.ic_fill_done = 1'b0;
    endtask

    // Asynchronous reset: outputs must change without waiting for a clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        EN_REG_FETCH = 1'b1; bus.itlb_miss = 1'b0; bus.ic_hit = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_ic_addr", bus.ic_addr, 32'h1000);
        chk("rst_miss_req", {31'b0, bus.ic_miss_req}, 32'd0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_pcnext", PCNEXT, 32'h0);
        chk("rst_pcinit", PC_INIT, 32'h0);
        chk("rst_tlb", {31'b0, TLB_MISS_INST}, 32'd0);
        @(posedge clk); #1;
        chk("rst_hold_addr", bus.ic_addr, 32'h1000);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
    endtask

    task automatic step(input int idx);
        vec_t  v;
        ifid_t e, got;
        v = tbl[idx];
        @(negedge clk);
        EN_REG_FETCH = v.en; flush = v.fl; branch_taken = v.br; branch_target = v.tgt;
        trap = v.tr; iret = v.ir; iret_pc = v.ipc;
        bus.itlb_miss = v.itlb; bus.ic_hit = v.hit; bus.ic_fill_done = v.fill;
        bus.ic_rdata = v.hit ? wd(v.e_addr) : 32'hDEAD_BEEF;
        #1;
        chk($sformatf("v%0d_ic_addr", idx), bus.ic_addr, v.e_addr);
        chk($sformatf("v%0d_miss_req", idx), {31'b0, bus.ic_miss_req}, {31'b0, v.e_req});
        chk($sformatf("v%0d_block", idx), {31'b0, block_pipe_instr_cache}, {31'b0, v.e_blk});
        e.ins = v.e_ins; e.pcn = v.e_pcn; e.pci = v.e_pci; e.tlb = v.e_tlb;
        sb.push_back(e);
        @(posedge clk); #1;
        got = '{instruction, PCNEXT, PC_INIT, TLB_MISS_INST};
        e = sb.pop_front();
        chk($sformatf("v%0d_instr", idx), got.ins, e.ins);
        chk($sformatf("v%0d_pcnext", idx), got.pcn, e.pcn);
        chk($sformatf("v%0d_pcinit", idx), got.pci, e.pci);
        chk($sformatf("v%0d_tlb", idx), {31'b0, got.tlb}, {31'b0, e.tlb});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        // en fl br tgt tr ir ipc itlb hit fill | addr req blk | ins pcn pci tlb
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0, 32'h1000,0,0, wd(32'h1000),32'h1004,32'h1000,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0, 32'h1004,0,0, wd(32'h1004),32'h1008,32'h1004,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, 32'h1008,1,1, wd(32'h1004),32'h1008,32'h1004,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, 32'h1008,0,1, wd(32'h1004),32'h1008,32'h1004,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,1, 32'h1008,0,1, wd(32'h1004),32'h1008,32'h1004,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0, 32'h1008,0,0, wd(32'h1008),32'h100C,32'h1008,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0, 32'h100C,0,0, wd(32'h100C),32'h1010,32'h100C,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,1,0,0, 32'h1010,0,0, 32'h0,32'h1014,32'h1010,1));
        tbl.push_back(mk(1,0,0,0,1,0,0,1,0,0, 32'h1010,0,0, 32'h0,32'h0,32'h0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0, 32'h2000,0,0, wd(32'h2000),32'h2004,32'h2000,0));
        tbl.push_back(mk(1,0,1,32'h5000,0,1,32'h1010,0,0,0, 32'h2004,0,0, 32'h0,32'h0,32'h0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0, 32'h1010,0,0, wd(32'h1010),32'h1014,32'h1010,0));
        tbl.push_back(mk(1,0,1,32'h3000,1,0,0,0,0,0, 32'h1014,0,0, 32'h0,32'h0,32'h0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0, 32'h2000,0,0, wd(32'h2000),32'h2004,32'h2000,0));
        // Branch arrives while the miss at 0x2004 is outstanding
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, 32'h2004,1,1, wd(32'h2000),32'h2004,32'h2000,0));
        tbl.push_back(mk(1,0,1,32'h3000,0,0,0,0,0,0, 32'h2004,0,1, wd(32'h2000),32'h2004,32'h2000,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0, 32'h2004,0,1, wd(32'h2000),32'h2004,32'h2000,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,1, 32'h2004,0,1, wd(32'h2000),32'h2004,32'h2000,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0, 32'h3000,0,0, wd(32'h3000),32'h3004,32'h3000,0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,0,0,0,0,0,0,0,1,0, 32'h3004,0,0, wd(32'h3000),32'h3004,32'h3000,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,1,0, 32'h3004,0,0, 32'h0,32'h0,32'h0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0, 32'h3004,0,0, wd(32'h3004),32'h3008,32'h3004,0));
        tbl.push_back(mk(0,0,1,32'hFFFF_FFFC,0,0,0,0,1,0, 32'h3008,0,0, wd(32'h3004),32'h3008,32'h3004,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0, 32'hFFFF_FFFC,0,0, wd(32'hFFFF_FFFC),32'h0,32'hFFFF_FFFC,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0, 32'h0,0,0, wd(32'h0),32'h4,32'h0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, 32'h4,1,1, wd(32'h0),32'h4,32'h0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, 32'h4,0,1, wd(32'h0),32'h4,32'h0,0));
        // After mid-miss reset: stray fill_done in RUN, then trap held over a later branch
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,1, 32'h1000,0,0, wd(32'h1000),32'h1004,32'h1000,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0, 32'h1004,1,1, wd(32'h1000),32'h1004,32'h1000,0));
        tbl.push_back(mk(1,0,0,0,1,0,0,0,0,0, 32'h1004,0,1, wd(32'h1000),32'h1004,32'h1000,0));
        tbl.push_back(mk(1,0,1,32'h3000,0,0,0,0,0,0, 32'h1004,0,1, wd(32'h1000),32'h1004,32'h1000,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,1, 32'h1004,0,1, wd(32'h1000),32'h1004,32'h1000,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,0, 32'h2000,0,0, wd(32'h2000),32'h2004,32'h2000,0));

        do_reset();
        for (int i = 0; i < 32; i++) step(i);
        do_reset();
        for (int i = 32; i < tbl.size(); i++) step(i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
